// File: rtl/ipmred_setup_seq_if.sv
// Random-byte stream between the RNG (master) and the IPM-RED setup engine (slave).
interface ipmred_setup_seq_if;
    logic [7:0] rnd_byte;
    logic       rnd_valid;
    logic       rnd_ready;

    modport master (output rnd_byte, output rnd_valid, input rnd_ready);
    modport slave  (input rnd_byte, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/ipmred_setup_seq.sv
// IPM-RED setup engine: fetches random bytes into L1/L2, then computes L1_hat/L2_hat serially.
// Optional IPMRED_NONZERO_RAND_EN: discard zero random bytes so every random L entry is nonzero.
module ipmred_setup_seq #(
    parameter int V = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    ipmred_setup_seq_if.slave            rnd,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid,
    output logic [V*8-1:0]               L1,
    output logic [V*8-1:0]               L2,
    output logic [(V-1)*(V-1)*8-1:0]     L1_hat,
    output logic [(V-1)*(V-1)*8-1:0]     L2_hat
);

    localparam int NB = 2 * (V - 2);
    localparam int NE = (V - 1) * (V - 1);
    localparam int KW = $clog2(NB + 1);
    localparam int IW = $clog2(V);
    localparam int EW = $clog2(NE + 1);

    typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [IW-1:0] i, j;
    logic          drain;
    logic [7:0]    l1a_p0, l1b_p0, l2a_p0, l2b_p0;
    logic [EW-1:0] idx_p0;
    logic          vld_p0;
    logic          accept;
    logic          keep;

    function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // L1_ drops L1[1]; L2_ drops L2[0].
    function automatic logic [7:0] l1_red(input logic [V*8-1:0] l, input logic [IW-1:0] n);
        return (n == '0) ? l[7:0] : l[8*(int'(n)+1) +: 8];
    endfunction

    function automatic logic [7:0] l2_red(input logic [V*8-1:0] l, input logic [IW-1:0] n);
        return l[8*(int'(n)+1) +: 8];
    endfunction

    assign rnd.rnd_ready = (state == FETCH);
    assign busy          = (state == FETCH) || (state == COMPUTE);
    assign accept        = rnd.rnd_valid && rnd.rnd_ready;

    always_comb begin
        keep = 1'b1;
`ifdef IPMRED_NONZERO_RAND_EN
        keep = (rnd.rnd_byte != 8'h00);
`else
        keep = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            i         <= '0;
            j         <= '0;
            drain     <= 1'b0;
            vld_p0    <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            L1        <= '0;
            L2        <= '0;
            L1_hat    <= '0;
            L2_hat    <= '0;
        end else begin
            done   <= 1'b0;
            vld_p0 <= 1'b0;

            // p1: write back the product issued last cycle
            if (vld_p0) begin
                L1_hat[8*int'(idx_p0) +: 8] <= gmul8(l1a_p0, l1b_p0);
                L2_hat[8*int'(idx_p0) +: 8] <= gmul8(l2a_p0, l2b_p0);
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= FETCH;
                        out_valid  <= 1'b0;
                        k          <= '0;
                        L1[15:0]   <= 16'h0001;
                        L2[15:0]   <= 16'h0100;
                    end
                end
                FETCH: begin
                    if (accept && keep) begin
                        if (k[0]) L2[8*(2+int'(k >> 1)) +: 8] <= rnd.rnd_byte;
                        else      L1[8*(2+int'(k >> 1)) +: 8] <= rnd.rnd_byte;
                        if (k == KW'(NB - 1)) begin
                            state <= COMPUTE;
                            k     <= '0;
                            i     <= '0;
                            j     <= '0;
                            drain <= 1'b0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    // p0: latch operands for entry (i,j); the final cycle only drains p1
                    if (!drain) begin
                        l1a_p0 <= l1_red(L1, i);
                        l1b_p0 <= l1_red(L1, j);
                        l2a_p0 <= l2_red(L2, i);
                        l2b_p0 <= l2_red(L2, j);
                        idx_p0 <= EW'(int'(i) * (V - 1) + int'(j));
                        vld_p0 <= 1'b1;
                        if (j == IW'(V - 2)) begin
                            j <= '0;
                            if (i == IW'(V - 2)) drain <= 1'b1;
                            else                 i     <= i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        state     <= DONE;
                        drain     <= 1'b0;
                        done      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
